pa_pwr_seq: RTL

Power-sequencing controller for one switchable domain, such as the 8b10b encoder or decoder. It generates the power-switch, isolation, retention and domain-reset controls that the power-aware environment consumes on ENC_/DEC_ PS_CTRL, ISO and RET. It turns a level power request into the ordered, timed control sequence. It sits in the always-on domain, and one instance is used per switchable domain.

---
 rtl/pa_pkg.sv | 25 ++
 rtl/pa_dly_cnt.sv | 38 +++
 rtl/pa_pwr_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pa_pkg.sv
// Shared types and default timing for the power-sequencing controller.
//   pwr_state_t : sequencer states
//   Def*        : default cycle counts used as parameter defaults by pa_pwr_seq
package pa_pkg;

    typedef enum logic [3:0] {
        StOff,
        StOffRet,
        StUpPs,
        StUpRst,
        StUpRet,
        StUpIso,
        StOn,
        StDnRet,
        StDnIso,
        StDnPs
    } pwr_state_t;

    localparam int unsigned DefTRet       = 4;
    localparam int unsigned DefTIso       = 4;
    localparam int unsigned DefTRst       = 8;
    localparam int unsigned DefAckTimeout = 64;
    localparam int unsigned DefCw         = 8;

endpackage

// File: rtl/pa_dly_cnt.sv
// Loadable down-counter shared by every timed wait of the sequencer.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (count -> 0)
//   load_i     : load load_val_i on the next edge (wins over counting)
//   load_val_i : value to load
//   zero_o     : count has reached zero; the counter holds at zero
module pa_dly_cnt #(
    parameter int unsigned CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pa_pwr_seq.sv
// Power-sequencing controller for one switchable domain (always-on side).
// Turns the level request PWR_REQ into an ordered, timed sequence of
// power-switch, isolation, retention and domain-reset controls.
//   CLK, RST  : clock and synchronous active-high reset
//   PWR_REQ   : 1 = domain on requested
//   RET_EN    : sampled when leaving ON; 1 = warm (retention) power-down
//   PS_ACK    : supply-good feedback from the power switch
//   PS_CTRL   : power switch enable
//   ISO       : isolation, active-low (0 = outputs clamped)
//   RET       : retention save/hold
//   DOM_RSTn  : domain reset, active-low
//   PWR_STAT  : 1 only in ON
//   BUSY      : 1 while a sequence is in progress
//   ERR       : sticky PS_ACK timeout flag, cleared only by RST
// All outputs are registered.
module pa_pwr_seq
    import pa_pkg::*;
#(
    parameter int unsigned T_RET       = DefTRet,
    parameter int unsigned T_ISO       = DefTIso,
    parameter int unsigned T_RST       = DefTRst,
    parameter int unsigned ACK_TIMEOUT = DefAckTimeout,
    parameter int unsigned CW          = DefCw
) (
    input  logic CLK,
    input  logic RST,
    input  logic PWR_REQ,
    input  logic RET_EN,
    input  logic PS_ACK,
    output logic PS_CTRL,
    output logic ISO,
    output logic RET,
    output logic DOM_RSTn,
    output logic PWR_STAT,
    output logic BUSY,
    output logic ERR
);

    // A wait of N cycles loads N-1: the state then lasts exactly N cycles.
    localparam logic [CW-1:0] LdRet = CW'(T_RET - 1);
    localparam logic [CW-1:0] LdIso = CW'(T_ISO - 1);
    localparam logic [CW-1:0] LdRst = CW'(T_RST - 1);
    localparam logic [CW-1:0] LdAck = CW'(ACK_TIMEOUT - 1);

    pwr_state_t state_d, state_q;
    logic ps_ctrl_d, ps_ctrl_q;
    logic iso_d, iso_q;
    logic ret_d, ret_q;
    logic dom_rst_n_d, dom_rst_n_q;
    logic pwr_stat_d, pwr_stat_q;
    logic busy_d, busy_q;
    logic err_d, err_q;
    logic warm_d, warm_q;

    logic          cnt_load;
    logic [CW-1:0] cnt_val;
    logic          cnt_zero;

    pa_dly_cnt #(
        .CW(CW)
    ) u_dly_cnt (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        ps_ctrl_d   = ps_ctrl_q;
        iso_d       = iso_q;
        ret_d       = ret_q;
        dom_rst_n_d = dom_rst_n_q;
        pwr_stat_d  = pwr_stat_q;
        busy_d      = busy_q;
        err_d       = err_q;
        warm_d      = warm_q;
        cnt_load    = 1'b0;
        cnt_val     = '0;

        unique case (state_q)
            StOff, StOffRet: begin
                if (PWR_REQ) begin
                    state_d   = StUpPs;
                    ps_ctrl_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_load  = 1'b1;
                    cnt_val   = LdAck;
                end
            end
            StUpPs: begin
                if (PS_ACK) begin
                    cnt_load = 1'b1;
                    if (warm_q) begin
                        state_d = StUpRet;
                        cnt_val = LdRet;
                    end else begin
                        state_d     = StUpRst;
                        dom_rst_n_d = 1'b0;
                        cnt_val     = LdRst;
                    end
                end else if (cnt_zero) begin
                    // Supply never came good: abandon to a cold OFF.
                    state_d     = StOff;
                    err_d       = 1'b1;
                    ps_ctrl_d   = 1'b0;
                    ret_d       = 1'b0;
                    dom_rst_n_d = 1'b0;
                    warm_d      = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            StUpRst: begin
                if (cnt_zero) begin
                    state_d     = StUpIso;
                    dom_rst_n_d = 1'b1;
                    cnt_load    = 1'b1;
                    cnt_val     = LdIso;
                end
            end
            StUpRet: begin
                if (cnt_zero) begin
                    state_d  = StUpIso;
                    ret_d    = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = LdIso;
                end
            end
            StUpIso: begin
                if (cnt_zero) begin
                    state_d    = StOn;
                    iso_d      = 1'b1;
                    pwr_stat_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            StOn: begin
                if (!PWR_REQ) begin
                    warm_d     = RET_EN;
                    pwr_stat_d = 1'b0;
                    busy_d     = 1'b1;
                    cnt_load   = 1'b1;
                    if (RET_EN) begin
                        state_d = StDnRet;
                        ret_d   = 1'b1;
                        cnt_val = LdRet;
                    end else begin
                        state_d = StDnIso;
                        iso_d   = 1'b0;
                        cnt_val = LdIso;
                    end
                end
            end
            StDnRet: begin
                if (cnt_zero) begin
                    state_d  = StDnIso;
                    iso_d    = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = LdIso;
                end
            end
            StDnIso: begin
                if (cnt_zero) begin
                    state_d   = StDnPs;
                    ps_ctrl_d = 1'b0;
                    cnt_load  = 1'b1;
                    cnt_val   = LdAck;
                end
            end
            StDnPs: begin
                // Leave on supply-gone or on timeout; a timeout only flags ERR.
                if (!PS_ACK || cnt_zero) begin
                    if (PS_ACK) begin
                        err_d = 1'b1;
                    end
                    busy_d = 1'b0;
                    if (warm_q) begin
                        state_d     = StOffRet;
                        ret_d       = 1'b1;
                        dom_rst_n_d = 1'b1;
                    end else begin
                        state_d     = StOff;
                        dom_rst_n_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StOff;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StOff;
            ps_ctrl_q   <= 1'b0;
            iso_q       <= 1'b0;
            ret_q       <= 1'b0;
            dom_rst_n_q <= 1'b0;
            pwr_stat_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            warm_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ps_ctrl_q   <= ps_ctrl_d;
            iso_q       <= iso_d;
            ret_q       <= ret_d;
            dom_rst_n_q <= dom_rst_n_d;
            pwr_stat_q  <= pwr_stat_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            warm_q      <= warm_d;
        end
    end

    assign PS_CTRL  = ps_ctrl_q;
    assign ISO      = iso_q;
    assign RET      = ret_q;
    assign DOM_RSTn = dom_rst_n_q;
    assign PWR_STAT = pwr_stat_q;
    assign BUSY     = busy_q;
    assign ERR      = err_q;

endmodule
